// File: rtl/lockstep_fault_manager_if.sv
// Comparator/recovery-control bundle between the lockstep comparator side and the
// fault manager.
interface lockstep_fault_manager_if #(
    parameter int unsigned MAX_RETRIES = 3
);
    localparam int unsigned RW = $clog2(MAX_RETRIES + 2);

    logic          cmp_fault;
    logic          cmp_valid;
    logic          fault_clr;
    logic          core_rst_n;
    logic          cmp_mask;
    logic          irq;
    logic          failsafe;
    logic [1:0]    state;
    logic [RW-1:0] retry_cnt;
    logic [15:0]   fault_total;

    modport master (
        output cmp_fault, cmp_valid, fault_clr,
        input  core_rst_n, cmp_mask, irq, failsafe, state, retry_cnt, fault_total
    );

    modport slave (
        input  cmp_fault, cmp_valid, fault_clr,
        output core_rst_n, cmp_mask, irq, failsafe, state, retry_cnt, fault_total
    );
endinterface

// File: rtl/lockstep_fault_manager.sv
// Recovery controller for the triple-core lockstep cluster: resets and resyncs the
// cores on a qualified mismatch and escalates to a latched failsafe past the retry budget.
module lockstep_fault_manager #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned MASK_CYCLES   = 8,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned WINDOW_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    lockstep_fault_manager_if.slave   bus
);
    localparam int unsigned RW        = $clog2(MAX_RETRIES + 2);
    localparam int unsigned PHASE_MAX = (RST_CYCLES > MASK_CYCLES) ? RST_CYCLES : MASK_CYCLES;
    localparam int unsigned PW        = $clog2(PHASE_MAX + 1);
    localparam int unsigned WW        = $clog2(WINDOW_CYCLES + 1);
    localparam int unsigned TW        = 16;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_RESET    = 2'd1,
        ST_RESYNC   = 2'd2,
        ST_FAILSAFE = 2'd3
    } state_t;

    state_t        state_q,      state_d;
    logic [PW-1:0] phase_q,      phase_d;
    logic [WW-1:0] win_q,        win_d;
    logic [RW-1:0] retry_q,      retry_d;
    logic [TW-1:0] total_q,      total_d;
    logic          irq_q,        irq_d;
    logic          core_rst_n_q, core_rst_n_d;
    logic          cmp_mask_q,   cmp_mask_d;
    logic          failsafe_q,   failsafe_d;
    logic          det_c;

    // Mask is already high outside NORMAL; the state term keeps the intent explicit.
    assign det_c = bus.cmp_valid & bus.cmp_fault & ~cmp_mask_q & (state_q == ST_NORMAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_NORMAL;
            phase_q      <= '0;
            win_q        <= '0;
            retry_q      <= '0;
            total_q      <= '0;
            irq_q        <= 1'b0;
            core_rst_n_q <= 1'b1;
            cmp_mask_q   <= 1'b0;
            failsafe_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            win_q        <= win_d;
            retry_q      <= retry_d;
            total_q      <= total_d;
            irq_q        <= irq_d;
            core_rst_n_q <= core_rst_n_d;
            cmp_mask_q   <= cmp_mask_d;
            failsafe_q   <= failsafe_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        win_d        = win_q;
        retry_d      = retry_q;
        total_d      = total_q;
        irq_d        = irq_q;
        core_rst_n_d = core_rst_n_q;
        cmp_mask_d   = cmp_mask_q;
        failsafe_d   = failsafe_q;

        // A new detection overrides a same-cycle acknowledge below.
        if (bus.fault_clr) begin
            irq_d = 1'b0;
        end

        unique case (state_q)
            ST_NORMAL: begin
                phase_d = '0;
                if (det_c) begin
                    irq_d        = 1'b1;
                    win_d        = '0;
                    core_rst_n_d = 1'b0;
                    cmp_mask_d   = 1'b1;
                    if (total_q != {TW{1'b1}}) begin
                        total_d = total_q + TW'(1);
                    end
                    if (retry_q == RW'(MAX_RETRIES)) begin
                        state_d    = ST_FAILSAFE;
                        failsafe_d = 1'b1;
                    end else begin
                        state_d = ST_RESET;
                        retry_d = retry_q + RW'(1);
                    end
                end else if (win_q == WW'(WINDOW_CYCLES - 1)) begin
                    win_d   = '0;
                    retry_d = '0;
                end else begin
                    win_d = win_q + WW'(1);
                end
            end

            ST_RESET: begin
                win_d = '0;
                if (phase_q == PW'(RST_CYCLES - 1)) begin
                    phase_d      = '0;
                    state_d      = ST_RESYNC;
                    core_rst_n_d = 1'b1;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end

            ST_RESYNC: begin
                win_d = '0;
                if (phase_q == PW'(MASK_CYCLES - 1)) begin
                    phase_d    = '0;
                    state_d    = ST_NORMAL;
                    cmp_mask_d = 1'b0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end

            ST_FAILSAFE: begin
                win_d   = '0;
                phase_d = '0;
            end
        endcase
    end

    assign bus.state       = state_q;
    assign bus.retry_cnt   = retry_q;
    assign bus.fault_total = total_q;
    assign bus.irq         = irq_q;
    assign bus.core_rst_n  = core_rst_n_q;
    assign bus.cmp_mask    = cmp_mask_q;
    assign bus.failsafe    = failsafe_q;
endmodule

// File: tb/tb_lockstep_fault_manager.sv
// Self-checking bench for lockstep_fault_manager: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a timestamp-based reference model.
module tb_lockstep_fault_manager;
    localparam int RST_C  = 16;
    localparam int MASK_C = 8;
    localparam int MAXR   = 3;
    localparam int WIN    = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    lockstep_fault_manager_if #(.MAX_RETRIES(MAXR)) bus ();

    lockstep_fault_manager #(
        .RST_CYCLES(RST_C), .MASK_CYCLES(MASK_C),
        .MAX_RETRIES(MAXR), .WINDOW_CYCLES(WIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Packed view: {core_rst_n, cmp_mask, irq, failsafe, state[1:0], retry[2:0], total[15:0]}
    function automatic logic [25:0] pack(logic rn, logic mk, logic iq, logic fs,
                                         logic [1:0] st, logic [2:0] rc, logic [15:0] tot);
        return {rn, mk, iq, fs, st, rc, tot};
    endfunction

    function automatic logic [25:0] dut_out();
        return pack(bus.core_rst_n, bus.cmp_mask, bus.irq, bus.failsafe,
                    bus.state, bus.retry_cnt, bus.fault_total);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic c);
        bus.cmp_valid = v;
        bus.cmp_fault = f;
        bus.fault_clr = c;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_mask_low(input string name);
        int n = 0;
        while (bus.cmp_mask !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.cmp_mask !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for cmp_mask low actual=%b expected=0", name, bus.cmp_mask);
        end
    endtask

    typedef struct {
        int         n;
        logic       v, f, c;
        logic [25:0] exp;
    } vec_t;

    // Reference model: recovery modeled as time intervals relative to the detection cycle.
    int   cyc, last_det, fs_at, win_origin, m_retry, m_total;
    logic m_irq;

    function automatic logic [1:0] m_state(int c);
        if (fs_at >= 0 && c >= fs_at) return 2'd3;
        if (c >= last_det + 1 && c <= last_det + RST_C) return 2'd1;
        if (c > last_det + RST_C && c <= last_det + RST_C + MASK_C) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [25:0] m_exp(int c);
        logic [1:0] st = m_state(c);
        return pack(st == 2'd0 || st == 2'd2, st != 2'd0, m_irq, st == 2'd3,
                    st, 3'(m_retry), 16'(m_total));
    endfunction

    task automatic model_reset();
        cyc = 0; last_det = -100000; fs_at = -1; win_origin = 0;
        m_retry = 0; m_total = 0; m_irq = 1'b0;
    endtask

    task automatic run_random(input int cycles, input int permille);
        logic v, f, c, det;
        logic [1:0] st;
        do_reset();
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            chk("random", 32'(dut_out()), 32'(m_exp(cyc)));
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 999) < permille);
            c = ($urandom_range(0, 19) == 0);
            drive(v, f, c);
            st  = m_state(cyc);
            det = (st == 2'd0) && v && f;
            if (det) begin
                if (m_total < 65535) m_total++;
                if (m_retry == MAXR) fs_at = cyc + 1;
                else begin
                    m_retry++;
                    last_det   = cyc;
                    win_origin = cyc + RST_C + MASK_C + 1;
                end
            end else if (st == 2'd0 && (cyc - win_origin + 1 == WIN)) begin
                m_retry    = 0;
                win_origin = cyc + 1;
            end
            if (det) m_irq = 1'b1;
            else if (c) m_irq = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    vec_t vecs[9];

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        // Single fault at cycle 10, masked/unqualified faults, irq handshake.
        vecs[0] = '{10, 1'b0, 1'b0, 1'b0, pack(1, 0, 0, 0, 2'd0, 3'd0, 16'd0)};
        vecs[1] = '{ 1, 1'b1, 1'b1, 1'b0, pack(0, 1, 1, 0, 2'd1, 3'd1, 16'd1)};
        vecs[2] = '{15, 1'b1, 1'b1, 1'b0, pack(0, 1, 1, 0, 2'd1, 3'd1, 16'd1)};
        vecs[3] = '{ 1, 1'b1, 1'b1, 1'b0, pack(1, 1, 1, 0, 2'd2, 3'd1, 16'd1)};
        vecs[4] = '{ 7, 1'b1, 1'b1, 1'b0, pack(1, 1, 1, 0, 2'd2, 3'd1, 16'd1)};
        vecs[5] = '{ 1, 1'b0, 1'b1, 1'b0, pack(1, 0, 1, 0, 2'd0, 3'd1, 16'd1)};
        vecs[6] = '{ 5, 1'b0, 1'b1, 1'b0, pack(1, 0, 1, 0, 2'd0, 3'd1, 16'd1)};
        vecs[7] = '{ 1, 1'b0, 1'b0, 1'b1, pack(1, 0, 0, 0, 2'd0, 3'd1, 16'd1)};
        vecs[8] = '{ 1, 1'b1, 1'b1, 1'b1, pack(0, 1, 1, 0, 2'd1, 3'd2, 16'd2)};

        do_reset();
        chk("reset_state", 32'(dut_out()), 32'(pack(1, 0, 0, 0, 2'd0, 3'd0, 16'd0)));
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].v, vecs[i].f, vecs[i].c);
            repeat (vecs[i].n) @(negedge clk);
            chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
        end

        // Escalation: four faults, each as soon as the mask drops.
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0);
            chk($sformatf("esc_state%0d", i), 32'(bus.state), (i < 3) ? 32'd1 : 32'd3);
            chk($sformatf("esc_retry%0d", i), 32'(bus.retry_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
            chk($sformatf("esc_total%0d", i), 32'(bus.fault_total), 32'(i + 1));
            if (i < 3) wait_mask_low("esc_wait");
        end
        drive(1'b1, 1'b1, 1'b0);
        repeat (50) @(negedge clk);
        chk("failsafe_hold", 32'(dut_out()), 32'(pack(0, 1, 1, 1, 2'd3, 3'd3, 16'd4)));
        drive(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        chk("failsafe_clr", 32'(dut_out()), 32'(pack(0, 1, 0, 1, 2'd3, 3'd3, 16'd4)));

        // Window expiry.
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        wait_mask_low("win_wait");
        repeat (WIN - 1) @(negedge clk);
        chk("win_before", 32'(bus.retry_cnt), 32'd1);
        @(negedge clk);
        chk("win_after", 32'(bus.retry_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0);
            wait_mask_low("win_wait2");
        end
        chk("win_recover", 32'(dut_out()), 32'(pack(1, 0, 1, 0, 2'd0, 3'd3, 16'd4)));

        // Asynchronous reset five cycles into RESET.
        do_reset();
        drive(1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        chk("pre_async", 32'(bus.state), 32'd1);
        #1 rst = 1'b0;
        #1 chk("async_rst", 32'(dut_out()), 32'(pack(1, 0, 0, 0, 2'd0, 3'd0, 16'd0)));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_async", 32'(dut_out()), 32'(pack(1, 0, 0, 0, 2'd0, 3'd0, 16'd0)));

        // Randomized traffic at several fault densities.
        run_random(3000, 1);
        run_random(2500, 2);
        run_random(1500, 20);
        run_random(2500, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
